// File: rtl/edge_timestamper.sv
`default_nettype none
// ============================================================================
// Module   : edge_timestamper
// Purpose  : Timestamps the earliest rising edge of each parallel sample word
//            into a FWFT FIFO and counts all rising edges (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module edge_timestamper #(
    parameter int N_IN       = 4,
    parameter int COARSE_W   = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_IN-1:0]                     din,
    input  logic                                enable,
    output logic                                ts_valid,
    input  logic                                ts_ready,
    output logic [COARSE_W+$clog2(N_IN)-1:0]    ts_data,
    output logic [CNT_W-1:0]                    edge_count,
    output logic                                overflow,
    input  logic                                clear_overflow
);

    localparam int KW  = $clog2(N_IN);
    localparam int NPW = $clog2(N_IN + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int TSW = COARSE_W + KW;

    logic [COARSE_W-1:0] r_coarse;
    logic                r_prev_lsb;
    logic                r_first_word;
    logic                r_hit;
    logic [TSW-1:0]      r_ts;
    logic [NPW-1:0]      r_npop;

    logic [N_IN-1:0]     w_edge;
    logic [KW-1:0]       w_kmin;
    logic [NPW-1:0]      w_npop;

    // w_edge is indexed by sample index k (k=0 is the MSB, earliest in time)
    always_comb begin
        w_edge    = '0;
        w_kmin    = '0;
        w_npop    = '0;
        w_edge[0] = din[N_IN-1] & ~r_prev_lsb & ~r_first_word;
        for (int k = 1; k < N_IN; k++) begin
            w_edge[k] = din[N_IN-1-k] & ~din[N_IN-k];
        end
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (w_edge[k]) w_kmin = KW'(k);
        end
        for (int k = 0; k < N_IN; k++) begin
            w_npop = w_npop + NPW'(w_edge[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coarse     <= '0;
            r_prev_lsb   <= 1'b0;
            r_first_word <= 1'b1;
            r_hit        <= 1'b0;
            r_ts         <= '0;
            r_npop       <= '0;
        end else begin
            r_coarse     <= r_coarse + COARSE_W'(1);
            r_prev_lsb   <= din[0];
            r_first_word <= 1'b0;
            r_hit        <= enable & (|w_edge);
            r_ts         <= {r_coarse, w_kmin};
            r_npop       <= enable ? w_npop : '0;
        end
    end

    logic [TSW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_edge_count;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [CNT_W:0]   w_sum;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = ~w_empty & ts_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push  = r_hit & (~w_full | w_pop);
    assign w_drop  = r_hit & w_full & ~w_pop;
    assign w_sum   = {1'b0, r_edge_count} + (CNT_W+1)'(r_npop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_ts;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_edge_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
            if (w_drop)              r_overflow <= 1'b1;
            else if (clear_overflow) r_overflow <= 1'b0;
            r_edge_count <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        end
    end

    assign ts_valid   = ~w_empty;
    assign ts_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign edge_count = r_edge_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_edge_timestamper.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_timestamper
// Purpose  : Directed self-checking bench for edge_timestamper (COARSE_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_timestamper;

    localparam int N_IN  = 4;
    localparam int CW    = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_IN-1:0]  din;
    logic             enable;
    logic             ts_valid;
    logic             ts_ready;
    logic [CW+1:0]    ts_data;
    logic [CNT_W-1:0] edge_count;
    logic             overflow;
    logic             clear_overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] cm;   // model of the coarse counter value at the next sampling edge
    logic [7:0] cs;
    logic [7:0] cf;

    edge_timestamper #(
        .N_IN       (N_IN),
        .COARSE_W   (CW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .enable         (enable),
        .ts_valid       (ts_valid),
        .ts_ready       (ts_ready),
        .ts_data        (ts_data),
        .edge_count     (edge_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) cm = 8'd0;
        else       cm = cm + 8'd1;
    endtask

    task automatic pop();
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
    endtask

    initial begin
        cm = 8'd0;
        reset = 1'b1; enable = 1'b1; din = 4'b1000; ts_ready = 1'b0; clear_overflow = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", ts_valid, 0);
        check("rst_data", ts_data, 0);
        check("rst_count", edge_count, 0);
        check("rst_ovf", overflow, 0);

        // first word after reset: MSB edge suppressed
        din = 4'b1000; tick();
        din = 4'b0100; tick();
        din = 4'b0000;
        check("first_nopush", ts_valid, 0);
        check("first_nocount", edge_count, 0);
        tick();
        check("second_valid", ts_valid, 1);
        check("second_data", ts_data, 10'h005);
        check("second_count", edge_count, 1);
        pop();
        check("second_popped", ts_valid, 0);

        // edge at sample index 2 captured at coarse=5
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (5) tick();
        din = 4'b0011; tick();
        din = 4'b0000;
        check("lat_early", ts_valid, 0);
        tick();
        check("lat_valid", ts_valid, 1);
        check("lat_data", ts_data, 10'h016);
        check("lat_count", edge_count, 1);
        pop();

        // two edges in one word: earliest stamped, both counted
        cs = cm; din = 4'b1010; tick();
        din = 4'b0000; tick();
        check("multi_data", ts_data, {cs, 2'd0});
        check("multi_count", edge_count, 3);
        pop();

        // word boundary: 0000->1000 edge at k=0, 0001->1000 none
        cs = cm; din = 4'b1000; tick();
        cf = cm; din = 4'b0001; tick();
        din = 4'b1000; tick();
        din = 4'b0000; tick(); tick();
        check("bnd_k0", ts_data, {cs, 2'd0});
        pop();
        check("bnd_k3", ts_data, {cf, 2'd3});
        pop();
        check("bnd_noedge", ts_valid, 0);
        check("bnd_count", edge_count, 5);

        // overflow: 17 edge words into 16 entries
        cf = cm; din = 4'b0100; repeat (17) tick();
        din = 4'b0000; tick(); tick();
        check("ovf_set", overflow, 1);
        check("ovf_count", edge_count, 22);
        din = 4'b0100; tick();
        din = 4'b0000; clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        check("ovf_drop_wins", overflow, 1);
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        check("ovf_cleared", overflow, 0);
        ts_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_valid", ts_valid, 1);
            check("drain_data", ts_data, {cf + 8'(i), 2'd1});
            tick();
        end
        ts_ready = 1'b0;
        check("drain_empty", ts_valid, 0);

        // full + push + pop in the same cycle: no drop
        cf = cm; din = 4'b0100; repeat (16) tick();
        din = 4'b0000; tick(); tick();
        cs = cm; din = 4'b0100; tick();
        din = 4'b0000; ts_ready = 1'b1; tick(); ts_ready = 1'b0;
        check("fullpop_noovf", overflow, 0);
        ts_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            check("fullpop_data", ts_data, {cf + 8'(i), 2'd1});
            tick();
        end
        check("fullpop_last", ts_data, {cs, 2'd1});
        tick();
        ts_ready = 1'b0;
        check("fullpop_empty", ts_valid, 0);
        check("fullpop_count", edge_count, 40);

        // mid-operation reset with entries buffered
        din = 4'b0100; repeat (3) tick();
        din = 4'b0000; tick(); tick();
        check("mid_buffered", ts_valid, 1);
        check("mid_count", edge_count, 43);
        reset = 1'b1; din = 4'b1000; tick(); reset = 1'b0;
        check("mid_rst_valid", ts_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_count", edge_count, 0);
        tick();
        din = 4'b0100; tick();
        din = 4'b0000; tick(); tick();
        check("mid_restart_data", ts_data, 10'h005);
        check("mid_restart_count", edge_count, 1);
        pop();

        // enable low: edges ignored, prev_lsb still tracked
        enable = 1'b0; din = 4'b0100; repeat (3) tick();
        din = 4'b1010; tick();
        din = 4'b0001; tick();
        enable = 1'b1; din = 4'b1000; tick();
        din = 4'b0000; tick(); tick();
        check("dis_nopush", ts_valid, 0);
        check("dis_count", edge_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
